// File: rtl/cond_logic_if.sv
// Decoder-to-conditional-stage bundle: request/condition inputs and gated outputs.
interface cond_logic_if;
  logic [3:0] Cond;      // instruction condition field, Instr[31:28]
  logic [3:0] ALUFlags;  // ALU result flags {N,Z,C,V}
  logic [1:0] FlagW;     // [1] updates N,Z; [0] updates C,V
  logic       PCS;       // decoder PC-write request
  logic       RegW;      // decoder register-write request
  logic       MemW;      // decoder memory-write request
  logic       NoWrite;   // suppress register write (compare/test ops)
  logic       PCSrc;     // gated PC select
  logic       RegWrite;  // gated register-file write enable
  logic       MemWrite;  // gated memory write enable
  logic       CondEx;    // condition passed
  logic [3:0] Flags;     // registered {N,Z,C,V}

  // Decoder side drives requests and observes the gated results.
  modport master (
    output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    input  PCSrc, RegWrite, MemWrite, CondEx, Flags
  );

  // Conditional-logic side.
  modport slave (
    input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
    output PCSrc, RegWrite, MemWrite, CondEx, Flags
  );
endinterface

// File: rtl/cond_logic.sv
// Conditional-execution stage: holds NZCV, evaluates the condition field
// against the registered flags and gates the decoder's write requests.
module cond_logic #(
  parameter logic [3:0] FLAG_RESET = 4'b0000
) (
  input logic         clk,
  input logic         Reset,
  cond_logic_if.slave bus
);

  // Condition codes, Instr[31:28].
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;

  logic [3:0] flags_reg;
  logic [3:0] flags_next;
  logic       cond_ex;
  logic       flag_n;
  logic       flag_z;
  logic       flag_c;
  logic       flag_v;

  assign flag_n = flags_reg[3];
  assign flag_z = flags_reg[2];
  assign flag_c = flags_reg[1];
  assign flag_v = flags_reg[0];

  // Condition decode; depends only on Cond and the registered flags so no
  // ALUFlags value can reach any output in the same cycle.
  always_comb begin
    cond_ex = 1'b1;
    case (bus.Cond)
      COND_EQ: cond_ex = flag_z;
      COND_NE: cond_ex = ~flag_z;
      COND_CS: cond_ex = flag_c;
      COND_CC: cond_ex = ~flag_c;
      COND_MI: cond_ex = flag_n;
      COND_PL: cond_ex = ~flag_n;
      COND_VS: cond_ex = flag_v;
      COND_VC: cond_ex = ~flag_v;
      COND_HI: cond_ex = flag_c & ~flag_z;
      COND_LS: cond_ex = ~flag_c | flag_z;
      COND_GE: cond_ex = (flag_n == flag_v);
      COND_LT: cond_ex = (flag_n != flag_v);
      COND_GT: cond_ex = ~flag_z & (flag_n == flag_v);
      COND_LE: cond_ex = flag_z | (flag_n != flag_v);
      default: cond_ex = 1'b1;  // AL and 1111 are unconditional
    endcase
  end

  // Next-state for each two-bit half: [1] -> N,Z and [0] -> C,V update
  // independently; a failed condition holds both halves.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_flag_half
      assign flags_next[2*gi+1 : 2*gi] = (bus.FlagW[gi] & cond_ex)
                                       ? bus.ALUFlags[2*gi+1 : 2*gi]
                                       : flags_reg[2*gi+1 : 2*gi];
    end
  endgenerate

  // Flags register; reset forces FLAG_RESET regardless of input values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      flags_reg <= FLAG_RESET;
    end else begin
      flags_reg <= flags_next;
    end
  end

  // Same-cycle gating of the decoder requests.
  assign bus.CondEx   = cond_ex;
  assign bus.PCSrc    = bus.PCS & cond_ex;
  assign bus.RegWrite = bus.RegW & cond_ex & ~bus.NoWrite;
  assign bus.MemWrite = bus.MemW & cond_ex;
  assign bus.Flags    = flags_reg;

endmodule

// File: doc/cond_logic.md
Name: cond_logic

Overview:
- Conditional-execution stage of the single-cycle ARM datapath. It sits between the decoder and the register file, data memory and PC mux.
- Holds the architectural NZCV status flags and evaluates the instruction's 4-bit condition field against them.
- Gates the decoder's write and branch requests into the final RegWrite (feeds the register file enable), MemWrite and PCSrc.
- Updates NZCV from ALU flags on flag-setting instructions that pass their condition.

Parameters:
- FLAG_RESET, 4'b0000, value loaded into {N,Z,C,V} on reset.

Ports:
- clk  input  1  system clock; flags update on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  current ALU result flags {N,Z,C,V}.
- FlagW  input  2  flag write request: [1] updates N,Z; [0] updates C,V.
- PCS  input  1  decoder PC-write request (branch or write to R15).
- RegW  input  1  decoder register-write request.
- MemW  input  1  decoder memory-write request.
- NoWrite  input  1  suppresses the register write (CMP/CMN/TST/TEQ).
- PCSrc  output  1  gated PC select.
- RegWrite  output  1  gated register-file write enable.
- MemWrite  output  1  gated memory write enable.
- CondEx  output  1  condition-pass indicator.
- Flags  output  4  current registered {N,Z,C,V}.

Behaviour:
- State: one 4-bit flags register {N,Z,C,V}, bit 3 = N.
- Reset asserted, asynchronously: Flags = FLAG_RESET immediately, regardless of clk. While Reset is high, Flags holds FLAG_RESET and no update occurs.
- Outputs are combinational from Cond and the registered Flags. Reset values with FLAG_RESET = 0 and all requests low: PCSrc = 0, RegWrite = 0, MemWrite = 0. CondEx then follows Cond evaluated on the zero flags (e.g. Cond = EQ gives CondEx = 0).
- CondEx decode from the registered flags:
  - 0000 EQ: Z
  - 0001 NE: !Z
  - 0010 CS: C
  - 0011 CC: !C
  - 0100 MI: N
  - 0101 PL: !N
  - 0110 VS: V
  - 0111 VC: !V
  - 1000 HI: C & !Z
  - 1001 LS: !C | Z
  - 1010 GE: N == V
  - 1011 LT: N != V
  - 1100 GT: !Z & (N == V)
  - 1101 LE: Z | (N != V)
  - 1110 AL: 1
  - 1111: 1 (treated as unconditional)
- Gating, same cycle, zero latency:
  - PCSrc = PCS & CondEx
  - RegWrite = RegW & CondEx & !NoWrite
  - MemWrite = MemW & CondEx
- Flag update on rising clk when Reset is low:
  - if FlagW[1] & CondEx: Flags[3:2] <= ALUFlags[3:2]
  - if FlagW[0] & CondEx: Flags[1:0] <= ALUFlags[1:0]
  - The two halves are independent. FlagW = 2'b10 leaves C,V unchanged.
- CondEx for the update uses pre-edge flags. A flag-setting instruction's new flags are visible to the next instruction only, never to its own gating.
- A failed condition blocks all three writes and the flag update in that cycle. Flags hold.
- NoWrite affects RegWrite only. A CMP with FlagW = 2'b11 still updates flags.
- No combinational path from ALUFlags to any output. ALUFlags affects only the register's next state.
- Reset deasserted asynchronously: the first clk edge after deassertion may update flags normally.
- Inputs X while Reset is high must not corrupt Flags.

Test Plan:
- Reset = 1 mid-run with Flags = 4'b1111, no clk edge -> Flags = 4'b0000 immediately; after release with Cond = 4'b0000 (EQ), RegW = 1 -> CondEx = 0, RegWrite = 0.
- Cond = 4'b1110, FlagW = 2'b11, ALUFlags = 4'b0100, clk edge -> Flags = 4'b0100; next cycle Cond = EQ, RegW = 1, MemW = 1, PCS = 1 -> RegWrite = 1, MemWrite = 1, PCSrc = 1.
- Flags = 4'b0100, Cond = NE, FlagW = 2'b11, ALUFlags = 4'b1011, edge -> Flags stays 4'b0100 and all gated outputs = 0.
- Flags = 4'b0000, Cond = AL, FlagW = 2'b10, ALUFlags = 4'b1111, edge -> Flags = 4'b1100; then FlagW = 2'b01, ALUFlags = 4'b0010, edge -> Flags = 4'b1110.
- CMP: Cond = AL, RegW = 1, NoWrite = 1, FlagW = 2'b11, ALUFlags = 4'b1001 -> RegWrite = 0 same cycle; after edge Flags = 4'b1001.
- Sweep all 16 Cond values against all 16 registered Flags values -> CondEx matches the decode table in all 256 cases; 1110 and 1111 always give CondEx = 1.
